// File: rtl/lidar_bin_filter.sv
// lidar_bin_filter: streaming LiDAR point range-bin filter.
// Stage 0 registers the accepted point. Stage 1 (combinational on stage 0)
// bins it and decides pass/drop. Stage 2 is the output register.
// A single global advance moves every stage at once, so a stalled output
// freezes the whole pipe and deasserts in_ready in the same cycle.
// Optional feature macro: BIN_FILTER_INTENSITY_EN adds a minimum-intensity gate
// (min_intensity port); intensity-rejected points are counted as drops.
module lidar_bin_filter #(
  parameter int unsigned BIN_SIZE = 500,
  parameter int unsigned NUM_BINS = 60,
  parameter int unsigned DIST_W   = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BIN_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_angle,
  input  logic [DIST_W-1:0]   in_distance,
  input  logic [7:0]          in_intensity,
  input  logic [7:0]          in_laser,
  input  logic [NUM_BINS-1:0] bin_mask,
`ifdef BIN_FILTER_INTENSITY_EN
  input  logic [7:0]          min_intensity,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_angle,
  output logic [DIST_W-1:0]   out_distance,
  output logic [7:0]          out_intensity,
  output logic [7:0]          out_laser,
  output logic [BIN_W-1:0]    out_bin,
  output logic                frame_done,
  output logic [CNT_W-1:0]    frame_pass_cnt,
  output logic [CNT_W-1:0]    frame_drop_cnt
);

  // Bin edge products need DIST_W+9 bits to stay overflow-free.
  localparam int unsigned PW = DIST_W + 9;

  logic              advance;
  logic              s0_valid;
  logic [15:0]       s0_angle;
  logic [DIST_W-1:0] s0_distance;
  logic [7:0]        s0_intensity;
  logic [7:0]        s0_laser;

  logic [PW-1:0]     dist_ext;
  logic [BIN_W-1:0]  s1_bin;
  logic              s1_mask_bit;
  logic              s1_hit;
  logic              s1_pass;
  logic              s1_eval;
  logic              s1_boundary;

  logic              angle_seen;
  logic [15:0]       prev_angle;
  logic [CNT_W-1:0]  run_pass_cnt;
  logic [CNT_W-1:0]  run_drop_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 0: capture the accepted point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid     <= 1'b0;
      s0_angle     <= '0;
      s0_distance  <= '0;
      s0_intensity <= '0;
      s0_laser     <= '0;
    end else if (advance) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_angle     <= in_angle;
        s0_distance  <= in_distance;
        s0_intensity <= in_intensity;
        s0_laser     <= in_laser;
      end
    end
  end

  // Stage 1: comparator array with thermometer-style priority encode.
  // The highest k with distance > BIN_SIZE*k is the bin; the upper bound
  // and the zero check together decide whether the point is in any bin.
  always_comb begin
    dist_ext    = PW'(s0_distance);
    s1_bin      = '0;
    s1_mask_bit = 1'b0;
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      if (dist_ext > PW'(BIN_SIZE) * PW'(k)) begin
        s1_bin      = BIN_W'(k);
        s1_mask_bit = bin_mask[k];
      end
    end
    s1_hit = (s0_distance != '0) &&
             (dist_ext <= PW'(BIN_SIZE) * PW'(NUM_BINS));
  end

`ifdef BIN_FILTER_INTENSITY_EN
  assign s1_pass = s1_hit && s1_mask_bit && (s0_intensity >= min_intensity);
`else
  assign s1_pass = s1_hit && s1_mask_bit;
`endif

  // A stage-1 point is evaluated once, on the cycle it leaves stage 1.
  assign s1_eval     = s0_valid && advance;
  assign s1_boundary = angle_seen && (s0_angle < prev_angle);

  // Stage 2: output register, loaded only with passing points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_angle     <= '0;
      out_distance  <= '0;
      out_intensity <= '0;
      out_laser     <= '0;
      out_bin       <= '0;
    end else if (advance) begin
      out_valid <= s0_valid && s1_pass;
      if (s0_valid && s1_pass) begin
        out_angle     <= s0_angle;
        out_distance  <= s0_distance;
        out_intensity <= s0_intensity;
        out_laser     <= s0_laser;
        out_bin       <= s1_bin;
      end
    end
  end

  // Frame statistics: running counts, boundary detection and latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_seen     <= 1'b0;
      prev_angle     <= '0;
      run_pass_cnt   <= '0;
      run_drop_cnt   <= '0;
      frame_done     <= 1'b0;
      frame_pass_cnt <= '0;
      frame_drop_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      if (s1_eval) begin
        angle_seen <= 1'b1;
        prev_angle <= s0_angle;
        if (s1_boundary) begin
          frame_done     <= 1'b1;
          frame_pass_cnt <= run_pass_cnt;
          frame_drop_cnt <= run_drop_cnt;
          run_pass_cnt   <= s1_pass ? CNT_W'(1) : '0;
          run_drop_cnt   <= s1_pass ? '0 : CNT_W'(1);
        end else if (s1_pass) begin
          run_pass_cnt <= sat_inc(run_pass_cnt);
        end else begin
          run_drop_cnt <= sat_inc(run_drop_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_lidar_bin_filter.sv
// Self-checking bench for lidar_bin_filter: directed vectors with
// hand-computed expectations. Build with +define+BIN_FILTER_INTENSITY_EN to
// exercise the intensity gate.
module tb_lidar_bin_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_angle;
  logic [15:0] in_distance;
  logic [7:0]  in_intensity;
  logic [7:0]  in_laser;
  logic [59:0] bin_mask;
`ifdef BIN_FILTER_INTENSITY_EN
  logic [7:0]  min_intensity;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_angle;
  logic [15:0] out_distance;
  logic [7:0]  out_intensity;
  logic [7:0]  out_laser;
  logic [5:0]  out_bin;
  logic        frame_done;
  logic [15:0] frame_pass_cnt;
  logic [15:0] frame_drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int st_ang [16];
  int st_dist[16];
  int st_int [16];
  bit exp_v  [16];
  int exp_bin[16];
  bit exp_fd [16];
  int exp_fpc[16];
  int exp_fdc[16];

  lidar_bin_filter #(
    .BIN_SIZE(500),
    .NUM_BINS(60),
    .DIST_W(16),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_angle(in_angle),
    .in_distance(in_distance),
    .in_intensity(in_intensity),
    .in_laser(in_laser),
    .bin_mask(bin_mask),
`ifdef BIN_FILTER_INTENSITY_EN
    .min_intensity(min_intensity),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_angle(out_angle),
    .out_distance(out_distance),
    .out_intensity(out_intensity),
    .out_laser(out_laser),
    .out_bin(out_bin),
    .frame_done(frame_done),
    .frame_pass_cnt(frame_pass_cnt),
    .frame_drop_cnt(frame_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) begin
      st_ang[i] = 0; st_dist[i] = 0; st_int[i] = 0;
      exp_v[i] = 1'b0; exp_bin[i] = 0; exp_fd[i] = 1'b0;
      exp_fpc[i] = 0; exp_fdc[i] = 0;
    end
  endtask

  // Drives n back-to-back points with out_ready high; point i is expected at
  // the output after the edge that follows its acceptance edge.
  task automatic run_stream(input int n, input string tag);
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        in_valid     = 1'b1;
        in_angle     = 16'(st_ang[i]);
        in_distance  = 16'(st_dist[i]);
        in_intensity = 8'(st_int[i]);
        in_laser     = 8'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      if (i >= 1) begin
        chk({tag, "_out_valid"}, out_valid, exp_v[i-1]);
        if (exp_v[i-1]) begin
          chk({tag, "_out_bin"}, out_bin, exp_bin[i-1]);
          chk({tag, "_out_dist"}, out_distance, st_dist[i-1]);
          chk({tag, "_out_angle"}, out_angle, st_ang[i-1]);
          chk({tag, "_out_laser"}, out_laser, i - 1);
        end
      end
      chk({tag, "_frame_done"}, frame_done, exp_fd[i]);
      chk({tag, "_pass_cnt"}, frame_pass_cnt, exp_fpc[i]);
      chk({tag, "_drop_cnt"}, frame_drop_cnt, exp_fdc[i]);
    end
  endtask

  initial begin
    int sent;
    int got;
    bit stall_prev;
    logic [15:0] held_d;
    logic [15:0] got_d[16];
    bit acc_in;
    bit acc_out;

    in_valid = 1'b0; in_angle = '0; in_distance = '0; in_intensity = '0;
    in_laser = '0; bin_mask = '1; out_ready = 1'b1; rst_n = 1'b0;
`ifdef BIN_FILTER_INTENSITY_EN
    min_intensity = 8'd0;
`endif

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_dist", out_distance, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pass_cnt", frame_pass_cnt, 0);
    chk("rst_drop_cnt", frame_drop_cnt, 0);

    // Bin edges, all bins enabled
    clear_exp();
    st_dist[0] = 0;     exp_v[0] = 0;
    st_dist[1] = 1;     exp_v[1] = 1; exp_bin[1] = 0;
    st_dist[2] = 500;   exp_v[2] = 1; exp_bin[2] = 0;
    st_dist[3] = 501;   exp_v[3] = 1; exp_bin[3] = 1;
    st_dist[4] = 30000; exp_v[4] = 1; exp_bin[4] = 59;
    st_dist[5] = 30001; exp_v[5] = 0;
    for (int i = 0; i < 6; i++) st_ang[i] = 10 * (i + 1);
    run_stream(6, "edge");

    // Mask only bin 1, then wrap to close the frame: 2 passed, 1 dropped
    do_reset();
    bin_mask = 60'h2;
    clear_exp();
    st_ang[0] = 10; st_dist[0] = 400; exp_v[0] = 0;
    st_ang[1] = 20; st_dist[1] = 700; exp_v[1] = 1; exp_bin[1] = 1;
    st_ang[2] = 30; st_dist[2] = 900; exp_v[2] = 1; exp_bin[2] = 1;
    st_ang[3] = 5;  st_dist[3] = 900; exp_v[3] = 1; exp_bin[3] = 1;
    exp_fd[4] = 1;
    for (int i = 4; i < 16; i++) begin exp_fpc[i] = 2; exp_fdc[i] = 1; end
    run_stream(4, "mask");
    bin_mask = '1;

    // Intensity gate
    do_reset();
    clear_exp();
    st_ang[0] = 10; st_dist[0] = 600; st_int[0] = 19;
    st_ang[1] = 20; st_dist[1] = 600; st_int[1] = 20;
    st_ang[2] = 5;  st_dist[2] = 600; st_int[2] = 20;
    exp_bin[0] = 1; exp_bin[1] = 1; exp_bin[2] = 1;
    exp_v[1] = 1; exp_v[2] = 1;
    exp_fd[3] = 1;
`ifdef BIN_FILTER_INTENSITY_EN
    min_intensity = 8'd20;
    exp_v[0] = 0;
    for (int i = 3; i < 16; i++) begin exp_fpc[i] = 1; exp_fdc[i] = 1; end
`else
    exp_v[0] = 1;
    for (int i = 3; i < 16; i++) begin exp_fpc[i] = 2; exp_fdc[i] = 0; end
`endif
    run_stream(3, "inten");
`ifdef BIN_FILTER_INTENSITY_EN
    min_intensity = 8'd0;
`endif

    // Backpressure: out_ready low for cycles 4..6 of a continuous stream
    do_reset();
    sent = 0; got = 0; stall_prev = 1'b0; held_d = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready    = !(c >= 4 && c <= 6);
      in_valid     = (sent < 8);
      in_distance  = 16'(600 + 500 * sent);
      in_angle     = 16'(100 + sent);
      in_intensity = 8'd0;
      in_laser     = 8'(sent);
      #1;
      if (!out_ready) chk("bp_in_ready", in_ready, 0);
      if (stall_prev) chk("bp_hold", out_distance, held_d);
      acc_in     = in_valid && in_ready;
      acc_out    = out_valid && out_ready;
      stall_prev = out_valid && !out_ready;
      held_d     = out_distance;
      if (acc_out) begin
        got_d[got] = out_distance;
        got++;
      end
      @(posedge clk); #1;
      if (acc_in) sent++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk("bp_count", got, 8);
    for (int i = 0; i < 8 && i < got; i++) chk("bp_order", got_d[i], 600 + 500 * i);

    // Frame wrap: 3 points then two descending angles
    do_reset();
    clear_exp();
    st_ang[0] = 100; st_ang[1] = 200; st_ang[2] = 300; st_ang[3] = 50; st_ang[4] = 40;
    for (int i = 0; i < 5; i++) begin st_dist[i] = 600; exp_v[i] = 1; exp_bin[i] = 1; end
    exp_fd[4] = 1; exp_fd[5] = 1;
    exp_fpc[4] = 3;
    for (int i = 5; i < 16; i++) exp_fpc[i] = 1;
    run_stream(5, "wrap");

    // Reset with two points in flight
    in_valid = 1'b1; in_angle = 16'd10; in_distance = 16'd600; in_laser = 8'd0;
    @(posedge clk); #1;
    in_angle = 16'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_dist", out_distance, 0);
    chk("rst_mid_pass_cnt", frame_pass_cnt, 0);
    chk("rst_mid_drop_cnt", frame_drop_cnt, 0);
    chk("rst_mid_frame_done", frame_done, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_post_out_valid", out_valid, 0);
    end

    // Running counts restarted by reset: next frame closes with 1 pass
    clear_exp();
    st_ang[0] = 100; st_ang[1] = 50;
    st_dist[0] = 600; st_dist[1] = 600;
    exp_v[0] = 1; exp_v[1] = 1; exp_bin[0] = 1; exp_bin[1] = 1;
    exp_fd[2] = 1;
    for (int i = 2; i < 16; i++) exp_fpc[i] = 1;
    run_stream(2, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lidar_bin_filter.md
# lidar_bin_filter

Streaming LiDAR point filter that classifies each point into one of NUM_BINS range bins of BIN_SIZE distance units and forwards only points whose bin is enabled in a runtime mask. It has a stall-capable valid/ready pipeline and per-frame pass/drop statistics. It sits between the LiDAR packet parser and the point buffer or clustering logic. It replaces the single-cycle, fixed 60-bin combinational point qualifier.

## Interface
Parameters:
- BIN_SIZE, 500: bin width in distance LSBs (1 m = 500).
- NUM_BINS, 60: number of range bins, from 1 to 256.
- DIST_W, 16: distance width.
- CNT_W, 16: frame statistic counter width.
- BIN_W, $clog2(NUM_BINS) (minimum 1): width of the bin index.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input point valid.
- in_ready, output, 1: input point accepted when high together with in_valid.
- in_angle, input, 16: point angle.
- in_distance, input, DIST_W: point distance.
- in_intensity, input, 8: point intensity.
- in_laser, input, 8: laser number.
- bin_mask, input, NUM_BINS: bit k = 1 passes bin k. Sampled in stage 1.
- min_intensity, input, 8: intensity threshold. Present only with the macro.
- out_valid, output, 1: output point valid.
- out_ready, input, 1: downstream ready.
- out_angle, output, 16: angle of the forwarded point.
- out_distance, output, DIST_W: distance of the forwarded point.
- out_intensity, output, 8: intensity of the forwarded point.
- out_laser, output, 8: laser number of the forwarded point.
- out_bin, output, BIN_W: bin index of the forwarded point.
- frame_done, output, 1: one-cycle pulse when a frame closes.
- frame_pass_cnt, output, CNT_W: points passed in the last closed frame.
- frame_drop_cnt, output, CNT_W: points dropped in the last closed frame.

## Operation
- Bin k covers (BIN_SIZE*k, BIN_SIZE*(k+1)]. distance = 0 belongs to no bin. distance > BIN_SIZE*NUM_BINS belongs to no bin. A point in no bin is always dropped.
- All bin products are computed at width DIST_W+9, so they cannot overflow.
- Stage 0 is the input register and captures the accepted point.
- Stage 1 runs the comparator array and a priority encoder producing bin_idx and hit.
- In stage 1, pass = hit & bin_mask[bin_idx].
- Stage 2 is the output register. It loads only passed points. Dropped points leave a bubble.
- Global advance = !out_valid | out_ready. in_ready = advance. Every stage moves only on advance.
- Frame boundary: a stage-1 point whose angle is strictly less than the previous stage-1 point's angle. The first point after reset is never a boundary.
- On a boundary:
  - frame_pass_cnt and frame_drop_cnt latch the running counts of the frame that just ended.
  - frame_done pulses for one cycle.
  - The running counts restart with the boundary point's own result, so the count becomes 0 or 1.
- Running counters saturate at 2^CNT_W-1 and never wrap.
- The previous-angle register updates on every valid stage-1 point, whether the point passes or drops.

## Timing
- Reset values: in_ready 1. out_valid 0. All out_* data 0. frame_done 0. Both frame counts 0. Running counts 0. Pipeline valid bits 0.
- Latency: a point accepted in cycle N, if it passes and there are no stalls, has out_valid high in cycle N+2.
- Throughput: 1 point/cycle while out_ready is high.
- While out_valid && !out_ready: all stages hold and in_ready is 0 in the same cycle (combinational). out_* stay stable.
- frame_done is asserted in the cycle after the boundary point is evaluated in stage 1. The frame counts are valid from that same cycle.
- A bin_mask change affects points evaluated in stage 1 on or after the cycle the change is applied.
- Reset asserted mid-stream clears everything immediately. In-flight points are lost.

## Configuration
- BIN_FILTER_INTENSITY_EN defined:
  - The min_intensity port exists.
  - In stage 1, pass additionally requires intensity >= min_intensity.
  - Points failing this test count as drops.
- BIN_FILTER_INTENSITY_EN undefined: the min_intensity port is absent and intensity plays no part in the decision.

## Test plan
- Bin edges, all bins enabled, out_ready = 1:
  - distances 0 and 30001 -> dropped.
  - distances 1, 500, 501 and 30000 -> passed with out_bin 0, 0, 1 and 59.
  - Each passed point reaches the output 2 cycles after acceptance.
- bin_mask = 60'h2 with distances 400, 700 and 900 -> only 700 and 900 are output, both with out_bin 1.
- Backpressure: a continuous stream of passing points, out_ready low for 3 cycles.
  - in_ready goes low in the same cycle out_ready drops.
  - No point is lost or duplicated, and output order is preserved.
- Frame wrap with all bins enabled:
  - Angles 100, 200, 300 at distance 600, then angle 50.
  - frame_done pulses once; frame_pass_cnt = 3, frame_drop_cnt = 0.
  - The next frame counts from 1.
- With the macro defined: min_intensity = 20, intensities 19 and 20 at distance 600 -> only the intensity-20 point passes, and the drop count increments by 1.
- Reset asserted while two points are in flight -> out_valid = 0 immediately, all counters are 0, and nothing is output after reset releases.
